// File: rtl/encryption_pkg.sv
// rtl/encryption_pkg.sv - shared width default and word type for the encryption datapath
package encryption_pkg;

  localparam int ENC_WIDTH_DEFAULT = 8;

  typedef logic [ENC_WIDTH_DEFAULT-1:0] enc_word_t;

endpackage : encryption_pkg

// File: rtl/encryption_module_sync_if.sv
// rtl/encryption_module_sync_if.sv - streaming data/key in, masked word out
interface encryption_module_sync_if
  import encryption_pkg::*;
#(
  parameter int N = ENC_WIDTH_DEFAULT
);

  logic         in_valid;
  logic [N-1:0] data_in;
  logic [N-1:0] key;
  logic         out_valid;
  logic [N-1:0] data_out;

  // Source side drives words and keys, consumes results
  modport master (
    output in_valid,
    output data_in,
    output key,
    input  out_valid,
    input  data_out
  );

  // Cipher stage side
  modport slave (
    input  in_valid,
    input  data_in,
    input  key,
    output out_valid,
    output data_out
  );

endinterface : encryption_module_sync_if

// File: rtl/encryption_mask_cell.sv
// rtl/encryption_mask_cell.sv - one-bit key mask: bit passes when key is 0, cleared when key is 1
module encryption_mask_cell (
  input  logic i_d,
  input  logic i_k,
  output logic o_q
);

  assign o_q = i_d & ~i_k;

endmodule : encryption_mask_cell

// File: rtl/encryption_module_sync.sv
// rtl/encryption_module_sync.sv - registered bitwise key-masking cipher stage
module encryption_module_sync
  import encryption_pkg::*;
#(
  parameter int N = ENC_WIDTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  encryption_module_sync_if.slave  bus
);

  logic [N-1:0] w_result;
  logic [N-1:0] r_data_out;
  logic         r_out_valid;

  // Bit-sliced mask array; each bit is independent so no cross-bit logic exists
  for (genvar g = 0; g < N; g++) begin : g_cell
    encryption_mask_cell u_cell (
      .i_d (bus.data_in[g]),
      .i_k (bus.key[g]),
      .o_q (w_result[g])
    );
  end

  // Output register: reset wins over a valid word; data holds while idle so junk on idle inputs is ignored
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data_out  <= '0;
      r_out_valid <= 1'b0;
    end else if (bus.in_valid) begin
      r_data_out  <= w_result;
      r_out_valid <= 1'b1;
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.data_out  = r_data_out;
  assign bus.out_valid = r_out_valid;

endmodule : encryption_module_sync

// File: tb/tb_encryption_module_sync.sv
// tb/tb_encryption_module_sync.sv - directed and randomised checks of the masking stage at N = 8, 1, 32
module tb_encryption_module_sync;

  logic clk;
  logic rst_n;

  int n_vec;
  int n_miss;

  encryption_module_sync_if #(.N(8))  bus8  ();
  encryption_module_sync_if #(.N(1))  bus1  ();
  encryption_module_sync_if #(.N(32)) bus32 ();

  encryption_module_sync #(.N(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  encryption_module_sync #(.N(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  encryption_module_sync #(.N(32)) u_dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus32.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive8(input logic v, input logic [7:0] d, input logic [7:0] k);
    bus8.in_valid = v;
    bus8.data_in  = d;
    bus8.key      = k;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  m8;
  logic [0:0]  m1;
  logic [31:0] m32;
  logic        v8, v1, v32;
  logic [7:0]  d8, k8;
  logic [0:0]  d1, k1;
  logic [31:0] d32, k32;

  initial begin
    n_vec  = 0;
    n_miss = 0;

    rst_n = 1'b0;
    drive8(1'b1, 8'hFF, 8'h00);
    bus1.in_valid  = 1'b1; bus1.data_in  = 1'b1;  bus1.key  = 1'b0;
    bus32.in_valid = 1'b1; bus32.data_in = '1;    bus32.key = '0;

    // Reset held with a valid word present
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_data",  32'(bus8.data_out), 32'h00);
      check("rst_valid", 32'(bus8.out_valid), 32'h0);
      check("rst_data1", 32'(bus1.data_out), 32'h0);
      check("rst_data32", bus32.data_out, 32'h0);
    end

    rst_n = 1'b1;
    drive8(1'b0, 8'hFF, 8'h00);
    bus1.in_valid  = 1'b0;
    bus32.in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("post_rst_data",  32'(bus8.data_out), 32'h00);
      check("post_rst_valid", 32'(bus8.out_valid), 32'h0);
    end

    // Mixed and extreme vectors back-to-back
    drive8(1'b1, 8'b10101010, 8'b11001100); tick();
    check("mix1", 32'(bus8.data_out), 32'h22);
    check("mix1_v", 32'(bus8.out_valid), 32'h1);
    drive8(1'b1, 8'b01010101, 8'b00110011); tick();
    check("mix2", 32'(bus8.data_out), 32'h44);
    check("mix2_v", 32'(bus8.out_valid), 32'h1);
    drive8(1'b1, 8'h00, 8'hFF); tick();
    check("ext_zero", 32'(bus8.data_out), 32'h00);
    check("ext_zero_v", 32'(bus8.out_valid), 32'h1);
    drive8(1'b1, 8'hFF, 8'h00); tick();
    check("ext_pass", 32'(bus8.data_out), 32'hFF);
    drive8(1'b1, 8'hFF, 8'hFF); tick();
    check("ext_all", 32'(bus8.data_out), 32'h00);

    // Hold with undriven-looking inputs while idle
    drive8(1'b1, 8'b11110000, 8'b00110000); tick();
    check("hold_load", 32'(bus8.data_out), 32'hC0);
    drive8(1'b0, 8'hxx, 8'hxx);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_data",  32'(bus8.data_out), 32'hC0);
      check("hold_valid", 32'(bus8.out_valid), 32'h0);
    end

    // Reset mid-stream drops word 3
    drive8(1'b1, 8'h0F, 8'h01); tick();
    check("ms_w1", 32'(bus8.data_out), 32'h0E);
    drive8(1'b1, 8'hF0, 8'h10); tick();
    check("ms_w2", 32'(bus8.data_out), 32'hE0);
    rst_n = 1'b0;
    drive8(1'b1, 8'hFF, 8'h00); tick();
    check("ms_w3_data",  32'(bus8.data_out), 32'h00);
    check("ms_w3_valid", 32'(bus8.out_valid), 32'h0);
    rst_n = 1'b1;
    drive8(1'b1, 8'h3C, 8'h0C); tick();
    check("ms_w4_data",  32'(bus8.data_out), 32'h30);
    check("ms_w4_valid", 32'(bus8.out_valid), 32'h1);

    // Random stream on all three widths against a golden model
    m8  = 8'h30;
    m1  = 1'b0;
    m32 = 32'h0;
    for (int i = 0; i < 1000; i++) begin
      v8  = ($urandom_range(0, 3) != 0);
      v1  = ($urandom_range(0, 3) != 0);
      v32 = ($urandom_range(0, 3) != 0);
      d8  = 8'($urandom);  k8  = 8'($urandom);
      d1  = 1'($urandom);  k1  = 1'($urandom);
      d32 = $urandom;      k32 = $urandom;
      drive8(v8, d8, k8);
      bus1.in_valid  = v1;  bus1.data_in  = d1;  bus1.key  = k1;
      bus32.in_valid = v32; bus32.data_in = d32; bus32.key = k32;
      @(posedge clk);
      if (v8)  m8  = d8 & ~k8;
      if (v1)  m1  = d1 & ~k1;
      if (v32) m32 = d32 & ~k32;
      for (int r = 0; r < 2; r++) begin
        #(r == 0 ? 1 : 2);
        check("rnd8",    32'(bus8.data_out), 32'(m8));
        check("rnd8_v",  32'(bus8.out_valid), 32'(v8));
        check("rnd1",    32'(bus1.data_out), 32'(m1));
        check("rnd1_v",  32'(bus1.out_valid), 32'(v1));
        check("rnd32",   bus32.data_out, m32);
        check("rnd32_v", 32'(bus32.out_valid), 32'(v32));
        if (r == 0) begin
          drive8(~v8, ~d8, ~k8);
          bus1.data_in  = ~d1;
          bus32.data_in = ~d32;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_encryption_module_sync
